// File: rtl/v_hier_lane_arb.sv
// v_hier_lane_arb: round-robin arbiter sharing one 4-lane bit-slice datapath among four requesters
module v_hier_lane_arb #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [15:0] data_in,
  input  logic [3:0]  qvec,
  output logic [3:0]  avec,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [3:0]  result
);
  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d, w_q, w_d, pick;
  logic [3:0]  cnt_q, cnt_d, grant_q, grant_d, avec_q, avec_d, result_q, result_d;
  always_comb begin
    pick = ptr_q;
    for (int i = 3; i >= 0; i--)
      if (req[ptr_q + 2'(i)]) pick = ptr_q + 2'(i);
  end
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    avec_d   = avec_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = DRIVE;
        w_d     = pick;
        grant_d = 4'b0001 << pick;
        avec_d  = data_in[{pick, 2'b00} +: 4];
        cnt_d   = 4'(LAT - 1);
      end
      DRIVE: if (!req[w_q]) begin
        // requester withdrew: abandon without done, but still advance fairness
        state_d = IDLE;
        ptr_d   = w_q + 2'd1;
        cnt_d   = 4'd0;
        grant_d = 4'b0;
        avec_d  = 4'b0;
      end else if (cnt_q == 4'd0) begin
        state_d  = CAPTURE;
        result_d = qvec;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      CAPTURE: begin
        state_d = IDLE;
        ptr_d   = w_q + 2'd1;
        grant_d = 4'b0;
        avec_d  = 4'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      w_q      <= 2'd0;
      cnt_q    <= 4'd0;
      grant_q  <= 4'b0;
      avec_q   <= 4'b0;
      result_q <= 4'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      w_q      <= w_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      avec_q   <= avec_d;
      result_q <= result_d;
    end
  end
  assign grant  = grant_q;
  assign avec   = avec_q;
  assign result = result_q;
  assign done   = (state_q == CAPTURE) ? grant_q : 4'b0;
endmodule

// File: doc/v_hier_lane_arb.md
V_HIER_LANE_ARB -- requirements
Module: v_hier_lane_arb

Interface
REQ-001 SHALL have parameter LAT, default 1: cycles avec is held before qvec is sampled; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 4 bits: one request bit per requester 0..3; a requester holds its bit until its done bit pulses.
REQ-005 SHALL have port data_in, input, 16 bits: operand nibble for requester n on data_in[4n+3:4n].
REQ-006 SHALL have port avec, output, 4 bits: operand driven to the shared 4-lane bit-slice datapath.
REQ-007 SHALL have port qvec, input, 4 bits: result returned from the shared datapath.
REQ-008 SHALL have port grant, output, 4 bits: one-hot owner of the datapath; all zero when idle.
REQ-009 SHALL have port done, output, 4 bits: one-cycle pulse to the requester whose transaction completed.
REQ-010 SHALL have port result, output, 4 bits: captured qvec; valid in the done cycle; held until the next capture.

Function
REQ-011 SHALL implement an FSM with states IDLE, DRIVE and CAPTURE, and a 2-bit round-robin pointer ptr.
REQ-012 IDLE with req!=0 SHALL select as winner w the first set req bit searching ptr, ptr+1, ... mod 4.
REQ-013 On the IDLE-to-DRIVE edge, the block SHALL register grant=onehot(w), avec=data_in nibble w, and cnt=LAT-1.
REQ-014 IDLE with req==0 SHALL keep grant=0 and avec=0, with no state change.
REQ-015 DRIVE SHALL hold grant and avec stable, decrement cnt each cycle, and go to CAPTURE when cnt==0 and req[w] is still set.
REQ-016 The block SHALL register result=qvec on the DRIVE-to-CAPTURE edge.
REQ-017 CAPTURE SHALL last exactly 1 cycle.
REQ-018 During CAPTURE the block SHALL output done=onehot(w), with grant and avec still valid.
REQ-019 On the CAPTURE-to-IDLE edge the block SHALL set ptr=(w+1) mod 4 and clear grant and avec.
REQ-020 Latency SHALL be as follows: req sampled at edge k gives grant high for cycles k+1..k+LAT+1 and done high in cycle k+LAT+1.
REQ-021 Abort: if req[w] drops in any DRIVE cycle, the next edge SHALL go to IDLE with grant=0, avec=0, no done pulse, result unchanged and ptr=(w+1) mod 4.
REQ-022 Changes on data_in or on other req bits during DRIVE/CAPTURE SHALL NOT affect avec, grant or w.
REQ-023 After CAPTURE the block SHALL always pass through at least one IDLE cycle before the next grant.
REQ-024 ptr wrap: the pointer SHALL wrap from 3 to 0.
REQ-025 With all 4 req bits held continuously, grants SHALL rotate 0,1,2,3,0,... when starting from reset.
REQ-026 At most one grant bit and at most one done bit SHALL ever be set.
REQ-027 cnt SHALL be 4 bits wide.
REQ-028 LAT=1 SHALL give a single DRIVE cycle.

Reset
REQ-029 When reset is high at a rising edge, the next state SHALL be IDLE with ptr=0, cnt=0, grant=0, done=0, avec=0 and result=0, regardless of state.
REQ-030 Reset mid-DRIVE or mid-CAPTURE SHALL abandon the transaction with no done pulse.
REQ-031 Reset SHALL take priority over req.
REQ-032 req sampled at the first edge with reset low SHALL be arbitrated normally.

Verification
REQ-033 Scenario, single request with LAT=2: req=0001, data_in[3:0]=A, datapath qvec=~avec -> grant=0001 for 3 cycles, avec=A, done=0001 in the 3rd grant cycle, result=5.
REQ-034 Scenario, full contention with LAT=1: req=1111 held and re-asserted after each done -> grant sequence 0001,0010,0100,1000,0001, with 1 idle cycle between grants.
REQ-035 Scenario, pointer fairness: complete a transaction for requester 2, then set req=0101 -> grant=0100 is never given before grant=0001.
REQ-036 Scenario, abort with LAT=3: drop req[1] in the 2nd DRIVE cycle -> grant=0 on the next edge, no done, result keeps its old value, the next winner search starts at 2.
REQ-037 Scenario, reset mid-DRIVE: pulse reset for 1 cycle during DRIVE -> all outputs 0 and ptr=0; then req=1000 is granted normally.
REQ-038 Scenario, stability: toggle data_in and req[3:1] every cycle while requester 0 is granted -> avec and grant stay constant until CAPTURE ends.
